// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   - Front-end opcode constants (the NOP answers a stall_req bubble request)
//   - Starvation FSM state encoding
//   - Default register address / data widths
package rf_wb_arbiter_pkg;

  localparam logic [6:0] OP_NOP = 7'b0000000;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_LI  = 7'b1111111;

  localparam int unsigned DEF_AW = 5;
  localparam int unsigned DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    STALL = 2'd2
  } starve_state_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous DEPTH x W FIFO buffering multi-cycle unit results.
// Ports:
//   i_clk, i_rst_n   clock / asynchronous active-low reset (contents discarded)
//   i_push, i_wdata  write at tail (ignored while full)
//   i_pop            advance head (ignored while empty)
//   o_rdata          head entry (valid while !o_empty)
//   o_full, o_empty  occupancy flags
//   o_cnt            occupancy, 0..DEPTH
module rf_wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = DEF_AW + DEF_DW,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_cnt
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_cnt   = r_cnt;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between the non-stallable
// writeback pipeline and a multi-cycle result stream (valid/ready). Multi-cycle
// results are buffered in rf_wb_fifo and drained into pipeline bubbles; when
// the FIFO keeps losing arbitration, stall_req asks the front end for a NOP.
// Ports:
//   clk, rst_n                        clock / asynchronous active-low reset
//   pipe_vld, pipe_rd, pipe_data      pipeline write request (always wins)
//   mc_valid, mc_ready, mc_rd, mc_data multi-cycle result handshake
//   rf_wr_en, rf_wr_addr, rf_wr_data  registered RF write port (x0 never written)
//   stall_req                         registered one-cycle bubble request
//   fifo_cnt                          FIFO occupancy
// Optional (macro RF_WB_STATS_EN): stat_pipe_wr, stat_mc_wr, stat_stall
//   32-bit saturating event counters.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned DW         = DEF_DW,
  localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pipe_vld,
  input  logic [AW-1:0] pipe_rd,
  input  logic [DW-1:0] pipe_data,
  input  logic          mc_valid,
  output logic          mc_ready,
  input  logic [AW-1:0] mc_rd,
  input  logic [DW-1:0] mc_data,
  output logic          rf_wr_en,
  output logic [AW-1:0] rf_wr_addr,
  output logic [DW-1:0] rf_wr_data,
  output logic          stall_req,
  output logic [CW-1:0] fifo_cnt
`ifdef RF_WB_STATS_EN
  ,
  output logic [31:0]   stat_pipe_wr,
  output logic [31:0]   stat_mc_wr,
  output logic [31:0]   stat_stall
`endif
);

  localparam int unsigned SCW = $clog2(STARVE_MAX + 1);

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_lost;
  logic [AW+DW-1:0]     w_head;
  logic [AW-1:0]        w_head_rd;
  logic [DW-1:0]        w_head_data;
  logic [SCW-1:0]       w_cnt_inc;

  starve_state_e        r_state;
  logic [SCW-1:0]       r_cnt;

  assign mc_ready = !w_full;
  assign w_push   = mc_valid && !w_full;
  assign w_pop    = !pipe_vld && !w_empty;
  assign w_lost   = pipe_vld && !w_empty;
  assign {w_head_rd, w_head_data} = w_head;

  rf_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_wdata ({mc_rd, mc_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_cnt   (fifo_cnt)
  );

  // Winner's address/data are held when nobody writes; only the enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else if (pipe_vld) begin
      rf_wr_en   <= (pipe_rd != '0);
      rf_wr_addr <= pipe_rd;
      rf_wr_data <= pipe_data;
    end else if (w_pop) begin
      rf_wr_en   <= (w_head_rd != '0);
      rf_wr_addr <= w_head_rd;
      rf_wr_data <= w_head_data;
    end else begin
      rf_wr_en   <= 1'b0;
    end
  end

  // Lost cycle count including this one; from IDLE/STALL a lost cycle is the first.
  assign w_cnt_inc = (r_state == COUNT) ? r_cnt + 1'b1 : SCW'(1);

  // Starvation FSM; stall_req is high exactly while in STALL. Leaving STALL
  // always passes through IDLE or COUNT so the pulse never stretches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      stall_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE, COUNT: begin
          if (!w_lost) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            stall_req <= 1'b0;
          end else if (w_cnt_inc >= SCW'(STARVE_MAX)) begin
            r_state   <= STALL;
            r_cnt     <= '0;
            stall_req <= 1'b1;
          end else begin
            r_state   <= COUNT;
            r_cnt     <= w_cnt_inc;
            stall_req <= 1'b0;
          end
        end
        STALL: begin
          r_state   <= w_lost ? COUNT : IDLE;
          r_cnt     <= w_lost ? SCW'(1) : '0;
          stall_req <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          stall_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef RF_WB_STATS_EN
  logic w_pipe_wr;
  logic w_mc_wr;
  logic w_stall_set;

  assign w_pipe_wr   = pipe_vld && (pipe_rd != '0);
  assign w_mc_wr     = w_pop && (w_head_rd != '0);
  assign w_stall_set = w_lost && (r_state != STALL) && (w_cnt_inc >= SCW'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pipe_wr <= '0;
      stat_mc_wr   <= '0;
      stat_stall   <= '0;
    end else begin
      if (w_pipe_wr && (stat_pipe_wr != '1)) stat_pipe_wr <= stat_pipe_wr + 1'b1;
      if (w_mc_wr && (stat_mc_wr != '1))     stat_mc_wr   <= stat_mc_wr + 1'b1;
      if (w_stall_set && (stat_stall != '1)) stat_stall   <= stat_stall + 1'b1;
    end
  end
`endif

endmodule
